// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory arbiter / refresh controller.
//   state_t            : controller FSM states
//   REQ0 / REQ1        : requester identifiers used by the grant and response paths
//   MIN_REFRESH_PERIOD : smallest refresh period that leaves room for a 3-cycle refresh
//   rsp_tag_t          : read-response tag carried alongside an accepted read
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SERVE  = 2'd0,
    REF_RD = 2'd1,
    REF_WB = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int MIN_REFRESH_PERIOD = 8;

  typedef struct packed {
    logic issued;
    logic id;
  } rsp_tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter.
//   clk, reset : clock and synchronous active-high reset
//   req[1:0]   : request lines (already qualified by the caller)
//   advance    : a grant was taken this cycle; remember who won
//   gnt[1:0]   : one-hot (or zero) grant, combinational from req
// After reset the pointer names requester 1 as last granted, so requester 0
// wins the first tie.
module rr_arbiter2
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic       last_r;
  logic [1:0] gnt_s;

  // Last-granted pointer, updated only when a grant is actually taken
  always_ff @(posedge clk) begin
    if (reset) begin
      last_r <= REQ1;
    end else if (advance) begin
      last_r <= gnt_s[1];
    end else begin
      last_r <= last_r;
    end
  end

  // Grant: a lone requester wins outright; a tie goes to the one not granted last
  always_comb begin
    gnt_s = 2'b00;
    if (req == 2'b11) begin
      if (last_r == REQ1) begin
        gnt_s = 2'b01;
      end else begin
        gnt_s = 2'b10;
      end
    end else begin
      gnt_s = req;
    end
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Two-port arbiter and refresh scheduler in front of a single-port memory.
//   clk, reset              : clock, synchronous active-high reset
//   reqN_valid/write/addr/wdata : requester N command (N = 0, 1)
//   reqN_ready              : combinational grant; accepted when valid & ready
//   rspN_valid / rspN_rdata : read-data pulse, two edges after acceptance
//   mem_write_enb / mem_read_enb / mem_address / mem_data_in : registered memory command
//   mem_data_out            : memory read data, one cycle after the read command
// Refresh steals three cycles every REFRESH_PERIOD: issue a read of ref_addr,
// wait one cycle for the data, then write it back and advance ref_addr.
module mem_arbiter_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int width          = 4,
  parameter int data_width     = 8,
  parameter int REFRESH_PERIOD = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [width-1:0]      req0_addr,
  input  logic [data_width-1:0] req0_wdata,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [width-1:0]      req1_addr,
  input  logic [data_width-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic [data_width-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [data_width-1:0] rsp1_rdata,
  output logic                  mem_write_enb,
  output logic                  mem_read_enb,
  output logic [width-1:0]      mem_address,
  output logic [data_width-1:0] mem_data_in,
  input  logic [data_width-1:0] mem_data_out
);

  localparam int CNT_W = $clog2(REFRESH_PERIOD);

  if (REFRESH_PERIOD < MIN_REFRESH_PERIOD) begin : g_bad_refresh_period
    $error("REFRESH_PERIOD must be at least %0d", MIN_REFRESH_PERIOD);
  end

  state_t                state_r;
  state_t                state_nxt_s;
  logic [CNT_W-1:0]      ref_cnt_r;
  logic                  refresh_pending_r;
  logic [width-1:0]      ref_addr_r;

  logic                  serve_open_s;
  logic [1:0]            arb_req_s;
  logic [1:0]            arb_gnt_s;
  logic                  accept_s;

  logic                  sel_write_s;
  logic [width-1:0]      sel_addr_s;
  logic [data_width-1:0] sel_wdata_s;
  logic                  sel_id_s;

  logic                  cmd_we_s;
  logic                  cmd_re_s;
  logic [width-1:0]      cmd_addr_s;
  logic [data_width-1:0] cmd_din_s;
  rsp_tag_t              cmd_tag_s;

  logic                  mem_we_r;
  logic                  mem_re_r;
  logic [width-1:0]      mem_addr_r;
  logic [data_width-1:0] mem_din_r;

  // First pipe entry is the tag of the read just issued; the second entry is
  // kept one-hot per requester so the response strobes come straight off flops.
  rsp_tag_t              pipe_r;
  logic [1:0]            rsp_valid_r;

  // Clients are only served in SERVE when no refresh is waiting
  assign serve_open_s = (state_r == SERVE) && !refresh_pending_r;

  // Arbiter requests, masked while refresh owns the memory
  always_comb begin
    if (serve_open_s) begin
      arb_req_s = {req1_valid, req0_valid};
    end else begin
      arb_req_s = 2'b00;
    end
  end

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req_s),
    .advance (accept_s),
    .gnt     (arb_gnt_s)
  );

  assign accept_s   = |arb_gnt_s;
  assign req0_ready = arb_gnt_s[0];
  assign req1_ready = arb_gnt_s[1];

  // Command fields of whichever requester the arbiter picked
  always_comb begin
    if (arb_gnt_s[1]) begin
      sel_write_s = req1_write;
      sel_addr_s  = req1_addr;
      sel_wdata_s = req1_wdata;
      sel_id_s    = REQ1;
    end else begin
      sel_write_s = req0_write;
      sel_addr_s  = req0_addr;
      sel_wdata_s = req0_wdata;
      sel_id_s    = REQ0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= SERVE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = SERVE;
    case (state_r)
      SERVE: begin
        if (refresh_pending_r) begin
          state_nxt_s = REF_RD;
        end else begin
          state_nxt_s = SERVE;
        end
      end
      REF_RD:  state_nxt_s = REF_WB;
      REF_WB:  state_nxt_s = SERVE;
      default: state_nxt_s = SERVE;
    endcase
  end

  // FSM outputs: next memory command and response tag
  always_comb begin
    cmd_we_s   = 1'b0;
    cmd_re_s   = 1'b0;
    cmd_addr_s = mem_addr_r;
    cmd_din_s  = mem_din_r;
    cmd_tag_s  = '{issued: 1'b0, id: REQ0};
    case (state_r)
      SERVE: begin
        if (refresh_pending_r) begin
          cmd_re_s   = 1'b1;
          cmd_addr_s = ref_addr_r;
        end else if (accept_s) begin
          cmd_we_s   = sel_write_s;
          cmd_re_s   = !sel_write_s;
          cmd_addr_s = sel_addr_s;
          cmd_tag_s  = '{issued: !sel_write_s, id: sel_id_s};
          if (sel_write_s) begin
            cmd_din_s = sel_wdata_s;
          end else begin
            cmd_din_s = mem_din_r;
          end
        end else begin
          cmd_we_s = 1'b0;
        end
      end
      REF_RD: begin
        cmd_re_s = 1'b0;
      end
      REF_WB: begin
        // mem_data_out here is what the refresh read returned
        cmd_we_s   = 1'b1;
        cmd_addr_s = ref_addr_r;
        cmd_din_s  = mem_data_out;
      end
      default: begin
        cmd_we_s = 1'b0;
      end
    endcase
  end

  // Refresh timer: free-running, raises pending on every wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt_r         <= '0;
      refresh_pending_r <= 1'b0;
    end else if (ref_cnt_r == CNT_W'(REFRESH_PERIOD - 1)) begin
      ref_cnt_r         <= '0;
      refresh_pending_r <= 1'b1;
    end else begin
      ref_cnt_r <= ref_cnt_r + CNT_W'(1);
      if ((state_r == SERVE) && refresh_pending_r) begin
        refresh_pending_r <= 1'b0;
      end else begin
        refresh_pending_r <= refresh_pending_r;
      end
    end
  end

  // Refresh row pointer, advanced once per completed write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_addr_r <= '0;
    end else if (state_r == REF_WB) begin
      ref_addr_r <= ref_addr_r + width'(1);
    end else begin
      ref_addr_r <= ref_addr_r;
    end
  end

  // Registered memory command
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we_r   <= 1'b0;
      mem_re_r   <= 1'b0;
      mem_addr_r <= '0;
      mem_din_r  <= '0;
    end else begin
      mem_we_r   <= cmd_we_s;
      mem_re_r   <= cmd_re_s;
      mem_addr_r <= cmd_addr_s;
      mem_din_r  <= cmd_din_s;
    end
  end

  // Response pipe: tag follows the read until its data leaves the memory
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_r      <= '{issued: 1'b0, id: REQ0};
      rsp_valid_r <= 2'b00;
    end else begin
      pipe_r         <= cmd_tag_s;
      rsp_valid_r[0] <= pipe_r.issued && (pipe_r.id == REQ0);
      rsp_valid_r[1] <= pipe_r.issued && (pipe_r.id == REQ1);
    end
  end

  assign mem_write_enb = mem_we_r;
  assign mem_read_enb  = mem_re_r;
  assign mem_address   = mem_addr_r;
  assign mem_data_in   = mem_din_r;
  assign rsp0_valid    = rsp_valid_r[0];
  assign rsp1_valid    = rsp_valid_r[1];
  assign rsp0_rdata    = mem_data_out;
  assign rsp1_rdata    = mem_data_out;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Self-checking bench for mem_arbiter_ctrl with REFRESH_PERIOD = 16.
// The bench owns the memory array. A reference model works from cycle counts
// since reset: refresh windows, round-robin winner, a shadow copy of memory
// contents and the expected read responses (pushed into per-requester queues
// and popped by a separate monitor).
module tb_mem_arbiter_ctrl;

  localparam int W     = 4;
  localparam int DW    = 8;
  localparam int P     = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0, req0_write = 1'b0;
  logic [W-1:0]  req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_write = 1'b0;
  logic [W-1:0]  req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic          mem_write_enb, mem_read_enb;
  logic [W-1:0]  mem_address;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;

  always #5 clk = ~clk;

  mem_arbiter_ctrl #(.width(W), .data_width(DW), .REFRESH_PERIOD(P)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_write_enb(mem_write_enb), .mem_read_enb(mem_read_enb),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pattern(input int i);
    return DW'(i * 37 + 5);
  endfunction

  // Single-port memory: registered read data, reloaded with a known pattern in reset
  logic [DW-1:0] mem_arr [DEPTH];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_arr[i] <= pattern(i);
      mem_data_out <= '0;
    end else begin
      if (mem_write_enb) mem_arr[mem_address] <= mem_data_in;
      if (mem_read_enb) mem_data_out <= mem_arr[mem_address];
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t          exp_q0[$];
  exp_t          exp_q1[$];
  logic [DW-1:0] shadow [DEPTH];
  int            cyc = 0;
  int            last_id = 1;

  // Model: cyc = clock edges since reset released; refresh owns cycles
  // k*P, k*P+1, k*P+2 (k >= 1), read visible at k*P+1, write-back at k*P+3.
  always @(negedge clk) begin
    logic         blocked, e_r0, e_r1;
    int           m;
    logic [W-1:0] ra;
    if (reset) begin
      cyc     = -1;
      last_id = 1;
      exp_q0.delete();
      exp_q1.delete();
      for (int i = 0; i < DEPTH; i++) shadow[i] = pattern(i);
    end else begin
      cyc++;
      if (cyc >= P) begin
        m  = cyc / P;
        ra = W'((m - 1) % DEPTH);
        case (cyc % P)
          1: begin
            chk("ref_read_enb", {31'd0, mem_read_enb}, 32'd1);
            chk("ref_read_we", {31'd0, mem_write_enb}, 32'd0);
            chk("ref_read_addr", {28'd0, mem_address}, {28'd0, ra});
          end
          2: begin
            chk("ref_gap_re", {31'd0, mem_read_enb}, 32'd0);
            chk("ref_gap_we", {31'd0, mem_write_enb}, 32'd0);
          end
          3: begin
            chk("ref_wb_enb", {31'd0, mem_write_enb}, 32'd1);
            chk("ref_wb_re", {31'd0, mem_read_enb}, 32'd0);
            chk("ref_wb_addr", {28'd0, mem_address}, {28'd0, ra});
            chk("ref_wb_data", {24'd0, mem_data_in}, {24'd0, shadow[ra]});
          end
          default: ;
        endcase
      end
      chk("enables_exclusive", {31'd0, mem_read_enb & mem_write_enb}, 32'd0);

      blocked = (cyc >= P) && ((cyc % P) < 3);
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      if (!blocked) begin
        if (req0_valid && req1_valid) begin
          e_r0 = (last_id == 1);
          e_r1 = (last_id == 0);
        end else begin
          e_r0 = req0_valid;
          e_r1 = req1_valid;
        end
      end
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, e_r0});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, e_r1});

      if (e_r0) begin
        last_id = 0;
        if (req0_write) shadow[req0_addr] = req0_wdata;
        else exp_q0.push_back('{data: shadow[req0_addr], due: cyc + 2});
      end else if (e_r1) begin
        last_id = 1;
        if (req1_write) shadow[req1_addr] = req1_wdata;
        else exp_q1.push_back('{data: shadow[req1_addr], due: cyc + 2});
      end
    end
  end

  // Monitor: pops expected responses when they fall due and compares
  int mcyc = 0;
  always @(negedge clk) begin
    logic ev0, ev1;
    if (reset) begin
      mcyc = -1;
    end else begin
      mcyc++;
      ev0 = (exp_q0.size() > 0) && (exp_q0[0].due == mcyc);
      chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, ev0});
      if (ev0) begin
        chk("rsp0_rdata", {24'd0, rsp0_rdata}, {24'd0, exp_q0[0].data});
        void'(exp_q0.pop_front());
      end
      ev1 = (exp_q1.size() > 0) && (exp_q1[0].due == mcyc);
      chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, ev1});
      if (ev1) begin
        chk("rsp1_rdata", {24'd0, rsp1_rdata}, {24'd0, exp_q1[0].data});
        void'(exp_q1.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    bit            valid;
    bit            write;
    logic [W-1:0]  addr;
    logic [DW-1:0] wdata;
  } item_t;
  item_t dq0[$];
  item_t dq1[$];

  function automatic item_t mk(input bit v, input bit w, input int a, input int d);
    item_t it;
    it.valid = v;
    it.write = w;
    it.addr  = W'(a);
    it.wdata = DW'(d);
    return it;
  endfunction

  task automatic apply();
    req0_valid = (dq0.size() > 0) && dq0[0].valid;
    req0_write = (dq0.size() > 0) && dq0[0].write;
    req0_addr  = (dq0.size() > 0) ? dq0[0].addr : '0;
    req0_wdata = (dq0.size() > 0) ? dq0[0].wdata : '0;
    req1_valid = (dq1.size() > 0) && dq1[0].valid;
    req1_write = (dq1.size() > 0) && dq1[0].write;
    req1_addr  = (dq1.size() > 0) ? dq1[0].addr : '0;
    req1_wdata = (dq1.size() > 0) ? dq1[0].wdata : '0;
  endtask

  // Drive both item queues until drained; idle items last one cycle
  task automatic run(input int maxc);
    logic hs0, hs1;
    apply();
    for (int k = 0; k < maxc; k++) begin
      if (dq0.size() == 0 && dq1.size() == 0) break;
      @(negedge clk);
      hs0 = req0_valid & req0_ready;
      hs1 = req1_valid & req1_ready;
      @(posedge clk);
      #1;
      if (dq0.size() > 0 && (!dq0[0].valid || hs0)) void'(dq0.pop_front());
      if (dq1.size() > 0 && (!dq1[0].valid || hs1)) void'(dq1.pop_front());
      apply();
    end
    chk("drive_drained", dq0.size() + dq1.size(), 32'd0);
    dq0.delete();
    dq1.delete();
    apply();
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    apply();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_dut();

    // single write then read by requester 0
    dq0.push_back(mk(1, 1, 3, 8'hA5));
    dq0.push_back(mk(1, 0, 3, 0));
    run(50);
    repeat (4) @(posedge clk);
    #1;

    // contention: both writing continuously, then read back
    for (int i = 0; i < 4; i++) begin
      dq0.push_back(mk(1, 1, 1, 8'h10 + i));
      dq1.push_back(mk(1, 1, 2, 8'h20 + i));
    end
    dq0.push_back(mk(1, 0, 1, 0));
    dq1.push_back(mk(1, 0, 2, 0));
    run(100);

    // randomized traffic across many refresh windows
    for (int i = 0; i < 150; i++) begin
      dq0.push_back(mk($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
                       $urandom_range(DEPTH - 1, 0), $urandom_range(255, 0)));
      dq1.push_back(mk($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
                       $urandom_range(DEPTH - 1, 0), $urandom_range(255, 0)));
    end
    run(2000);
    repeat (300) @(posedge clk);
    #1;

    // reset the cycle after a read is accepted
    reset_dut();
    req0_valid = 1'b1;
    req0_write = 1'b0;
    req0_addr  = 4'd5;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_write_enb", {31'd0, mem_write_enb}, 32'd0);
    chk("rst_read_enb", {31'd0, mem_read_enb}, 32'd0);
    chk("rst_address", {28'd0, mem_address}, 32'd0);
    chk("rst_data_in", {24'd0, mem_data_in}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk);
    #1;

    // first tie after reset must go to requester 0 (checked by the model)
    dq0.push_back(mk(1, 0, 1, 0));
    dq1.push_back(mk(1, 0, 2, 0));
    dq0.push_back(mk(1, 1, 7, 8'h3C));
    dq1.push_back(mk(1, 0, 7, 0));
    run(50);
    repeat (40) @(posedge clk);
    #1;

    @(negedge clk);
    chk("exp_q0_empty", exp_q0.size(), 32'd0);
    chk("exp_q1_empty", exp_q1.size(), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("mem_final[%0d]", i), {24'd0, mem_arr[i]}, {24'd0, shadow[i]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_ctrl.md
# mem_arbiter_ctrl

Two-port arbiter and refresh scheduler that sits in front of the single-port DRAM block memory. It accepts read/write requests from two requesters over valid/ready handshakes, grants the memory round-robin, and returns read data with a fixed latency. It also periodically steals memory cycles to refresh one row by read-back and write-back.

## Interface
- width, 4, address width; the memory holds 2^width words.
- data_width, 8, data word width.
- REFRESH_PERIOD, 64, cycles between refresh requests; must be at least 8.

- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- req0_valid / req1_valid  in  1  request valid.
- req0_write / req1_write  in  1  1 = write, 0 = read.
- req0_addr / req1_addr  in  width  request address.
- req0_wdata / req1_wdata  in  data_width  write data.
- req0_ready / req1_ready  out  1  grant; the request is accepted on an edge where valid and ready are both high.
- rsp0_valid / rsp1_valid  out  1  read data valid, one-cycle pulse.
- rsp0_rdata / rsp1_rdata  out  data_width  read data, valid only when the matching rsp_valid is high.
- mem_write_enb  out  1  registered write enable to the memory.
- mem_read_enb  out  1  registered read enable to the memory.
- mem_address  out  width  registered memory address.
- mem_data_in  out  data_width  registered memory write data.
- mem_data_out  in  data_width  memory read data; registered inside the memory, valid one cycle after the read command.

## Operation
- FSM states: SERVE, REF_RD, REF_WB. Reset state is SERVE.
- **SERVE with refresh_pending = 0:**
  - Pick one valid requester. If both are valid, grant the one not granted last. After reset, the last-granted pointer selects requester 1, so requester 0 wins the first tie.
  - Drive ready combinationally to the chosen requester only.
  - On acceptance, register the command into mem_*. Exactly one of mem_write_enb or mem_read_enb is set, matching req_write.
  - With no accepted request, both enables register to 0.
- **SERVE with refresh_pending = 1:**
  - No ready is asserted.
  - Register a read of ref_addr into mem_*.
  - Clear refresh_pending and go to REF_RD.
- **REF_RD:**
  - No ready is asserted.
  - Both enables register to 0.
  - Go to REF_WB.
- **REF_WB:**
  - No ready is asserted.
  - Register a write of mem_data_out to ref_addr.
  - Increment ref_addr, wrapping from 2^width-1 to 0.
  - Go to SERVE.
- **Refresh timer:**
  - ref_cnt increments every cycle. At REFRESH_PERIOD-1 it wraps to 0 and sets refresh_pending.
  - The timer keeps counting during refresh.
- **Read responses:**
  - A 2-entry shift register carries {issued, requester id} alongside each accepted read.
  - rspN_valid is a registered pulse; rspN_rdata = mem_data_out.
  - Refresh reads and all writes produce no response.
- mem_write_enb and mem_read_enb are never both 1.
- **Reset:**
  - Clears state, ref_cnt, ref_addr, pending flag, pointer, response pipe, both enables and rsp_valid.
  - mem_address and mem_data_in reset to 0.
  - An in-flight read response is dropped, with no rsp_valid after reset.

## Timing
- Read accepted at edge E0: the memory sees the command in cycle E0–E1 and captures it at E1. rspN_valid is high in cycle E1–E2, so response latency is 2 edges.
- Write accepted at E0: the memory array is updated at E1.
- Back-to-back acceptance is allowed every cycle, giving a throughput of 1 request per cycle.
- Refresh occupies 3 cycles with no ready (the pending SERVE cycle, REF_RD, REF_WB).
- A client read accepted just before refresh still returns its response on schedule, overlapping REF_RD.
- Refresh write-back data is mem_data_out sampled in REF_WB, which is the value the refresh read returned.

## Structure
- Package mem_ctrl_pkg holds:
  - the state enum {SERVE, REF_RD, REF_WB};
  - requester-id constants REQ0 and REQ1;
  - minimum-REFRESH_PERIOD check constant.
- Sub-module rr_arbiter2 holds the two-input round-robin grant logic and last-granted pointer, with inputs req[1:0] and advance and output gnt[1:0]. All other logic lives in mem_arbiter_ctrl.

## Test plan
- **Single write then read:** requester 0 writes addr 3 = 0xA5, then reads addr 3 → rsp0_valid pulse 2 edges after acceptance with rsp0_rdata = 0xA5, and rsp1_valid stays 0.
- **Contention:**
  - Both valid continuously after reset, requester 0 writing addr 1 and requester 1 writing addr 2 → grants alternate 0,1,0,1.
  - Readback of addrs 1 and 2 returns each requester's last data.
- **Refresh cadence:** REFRESH_PERIOD=16 with idle requesters →
  - mem read and write of ref_addr 0 appear 2 cycles apart;
  - the next refresh targets addr 1;
  - after 16 refreshes ref_addr wraps to 0;
  - memory contents are unchanged.
- **Refresh vs traffic:**
  - Requester 1 holds valid through a refresh → ready is low for exactly 3 cycles.
  - A read accepted the cycle before pending is set still returns correct data on time.
- **Reset mid-read:** assert reset the cycle after a read is accepted →
  - no rsp_valid afterwards;
  - all outputs are 0 the cycle after reset;
  - the next tie grants requester 0.
